// File: rtl/uart_tx.sv
// UART transmitter: start bit, LSB-first data, optional parity, one or two stop
// bits, paced by an external baud-counter strobe that is cleared on acceptance.
module uart_tx #(
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic                 tick,
    output logic                 tick_clr,
    input  logic [DATA_BITS-1:0] in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic                 tx,
    output logic                 busy
);

    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
        $error("uart_tx: DATA_BITS must be in 5..9");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
        $error("uart_tx: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
        $error("uart_tx: STOP_BITS must be 1 or 2");
    end

    localparam int             CW       = $clog2(DATA_BITS + 1);
    localparam logic [CW-1:0]  LAST_BIT = CW'(DATA_BITS - 1);
    localparam logic           LAST_STOP = 1'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PAR,
        STOP
    } state_e;

    state_e                 state_q;
    logic [DATA_BITS-1:0]   shift_q;
    logic [CW-1:0]          bit_cnt_q;
    logic                   stop_cnt_q;
    logic                   par_q;
    logic                   tx_q;
    logic                   busy_q;

    logic                   accept;
    logic                   par_d;

    assign in_ready = (state_q == IDLE);
    assign accept   = in_ready & in_valid;
    assign tick_clr = accept;
    assign tx       = tx_q;
    assign busy     = busy_q;

    // Odd parity makes the total count of ones odd, so it is the inverted XOR.
    assign par_d = (PARITY == 1) ? ~^in_data : ^in_data;

    // NOTE: every register here is updated with <= so all of them see the
    // pre-edge values of each other; mixing in = would make order matter.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            stop_cnt_q <= 1'b0;
            par_q      <= 1'b0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    // tick is deliberately ignored here, including in the acceptance cycle
                    if (accept) begin
                        shift_q    <= in_data;
                        par_q      <= par_d;
                        bit_cnt_q  <= '0;
                        stop_cnt_q <= 1'b0;
                        tx_q       <= 1'b0;
                        busy_q     <= 1'b1;
                        state_q    <= START;
                    end
                end
                START: begin
                    if (tick) begin
                        tx_q    <= shift_q[0];
                        state_q <= DATA;
                    end
                end
                DATA: begin
                    if (tick) begin
                        shift_q   <= shift_q >> 1;
                        bit_cnt_q <= bit_cnt_q + CW'(1);
                        if (bit_cnt_q == LAST_BIT) begin
                            if (PARITY != 0) begin
                                tx_q    <= par_q;
                                state_q <= PAR;
                            end else begin
                                tx_q    <= 1'b1;
                                state_q <= STOP;
                            end
                        end else begin
                            tx_q <= shift_q[1];
                        end
                    end
                end
                PAR: begin
                    if (tick) begin
                        tx_q    <= 1'b1;
                        state_q <= STOP;
                    end
                end
                STOP: begin
                    if (tick) begin
                        if (stop_cnt_q == LAST_STOP) begin
                            stop_cnt_q <= 1'b0;
                            busy_q     <= 1'b0;
                            state_q    <= IDLE;
                        end else begin
                            stop_cnt_q <= stop_cnt_q + 1'b1;
                        end
                    end
                end
                default: begin
                    tx_q    <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: four configurations (8N1, 8E1, 8O1, 7N2), each fed by
// its own baud counter model; frames decoded off the line are checked against a scoreboard.
module tb_uart_tx;

    localparam int P = 16;
    localparam int DB  [4] = '{8, 8, 8, 7};
    localparam int PTY [4] = '{0, 2, 1, 0};
    localparam int SB  [4] = '{1, 1, 1, 2};

    typedef struct {
        int          k;
        logic [15:0] bits;
    } exp_t;

    logic        clk = 1'b0;
    logic        n_rst;
    logic [3:0]  in_valid_w;
    logic [3:0]  force_tick;
    logic [8:0]  in_data_w [4];
    logic [3:0]  tick_w;
    logic [3:0]  tick_clr_w;
    logic [3:0]  in_ready_w;
    logic [3:0]  tx_w;
    logic [3:0]  busy_w;

    int          checks = 0;
    int          errors = 0;
    exp_t        sb [$];
    logic [15:0] last_bits [4];
    int          frames_seen [4];

    always #5 clk = ~clk;

    uart_tx #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dut0 (
        .clk(clk), .n_rst(n_rst), .tick(tick_w[0]), .tick_clr(tick_clr_w[0]),
        .in_data(in_data_w[0][7:0]), .in_valid(in_valid_w[0]), .in_ready(in_ready_w[0]),
        .tx(tx_w[0]), .busy(busy_w[0]));
    uart_tx #(.DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) dut1 (
        .clk(clk), .n_rst(n_rst), .tick(tick_w[1]), .tick_clr(tick_clr_w[1]),
        .in_data(in_data_w[1][7:0]), .in_valid(in_valid_w[1]), .in_ready(in_ready_w[1]),
        .tx(tx_w[1]), .busy(busy_w[1]));
    uart_tx #(.DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) dut2 (
        .clk(clk), .n_rst(n_rst), .tick(tick_w[2]), .tick_clr(tick_clr_w[2]),
        .in_data(in_data_w[2][7:0]), .in_valid(in_valid_w[2]), .in_ready(in_ready_w[2]),
        .tx(tx_w[2]), .busy(busy_w[2]));
    uart_tx #(.DATA_BITS(7), .PARITY(0), .STOP_BITS(2)) dut3 (
        .clk(clk), .n_rst(n_rst), .tick(tick_w[3]), .tick_clr(tick_clr_w[3]),
        .in_data(in_data_w[3][6:0]), .in_valid(in_valid_w[3]), .in_ready(in_ready_w[3]),
        .tx(tx_w[3]), .busy(busy_w[3]));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference frame as seen on the line, bit 0 = start bit.
    function automatic logic [15:0] frame_bits(input int k, input logic [8:0] d);
        logic [15:0] f;
        logic        p;
        int          n;
        f = '0;
        p = 1'b0;
        for (int i = 0; i < DB[k]; i++) begin
            f[1+i] = d[i];
            p      = p ^ d[i];
        end
        n = 1 + DB[k];
        if (PTY[k] == 1) begin f[n] = ~p; n++; end
        if (PTY[k] == 2) begin f[n] = p;  n++; end
        for (int s = 0; s < SB[k]; s++) f[n+s] = 1'b1;
        return f;
    endfunction

    for (genvar k = 0; k < 4; k++) begin : g_lane
        localparam int NB = 1 + DB[k] + ((PTY[k] != 0) ? 1 : 0) + SB[k];
        logic [3:0]  baud;
        logic [15:0] obs;
        logic        stable;
        bit          aborted;
        int          bcnt;
        logic        prev_tick;
        exp_t        e;

        // Baud counter model: restarts on tick_clr, strobes once every P cycles.
        always_ff @(posedge clk or negedge n_rst) begin
            if (!n_rst)             baud <= '0;
            else if (tick_clr_w[k]) baud <= '0;
            else                    baud <= baud + 4'd1;
        end
        assign tick_w[k] = (baud == 4'd15) | force_tick[k];

        initial frames_seen[k] = 0;

        // Line monitor: decode a frame from the first low sample; every bit must hold P cycles.
        always begin
            @(negedge clk);
            if (n_rst === 1'b1 && tx_w[k] === 1'b0) begin
                obs     = '0;
                stable  = 1'b1;
                aborted = 1'b0;
                for (int s = 0; s < NB * P; s++) begin
                    if (s > 0) @(negedge clk);
                    if (n_rst !== 1'b1) begin
                        aborted = 1'b1;
                        break;
                    end
                    if (s % P == 0)                  obs[s/P] = tx_w[k];
                    else if (tx_w[k] !== obs[s/P])   stable   = 1'b0;
                end
                if (!aborted) begin
                    last_bits[k] = obs;
                    frames_seen[k]++;
                    check("sb_has_entry", 32'(sb.size() > 0), 32'd1);
                    if (sb.size() > 0) begin
                        e = sb.pop_front();
                        check("frame_lane", e.k, k);
                        check("frame_bits", 32'(obs), 32'(e.bits));
                        check("bit_width", 32'(stable), 32'd1);
                    end
                end
            end
        end

        // Busy monitor: frame length, and in_ready back the cycle after the final stop tick.
        always @(negedge clk) begin
            if (n_rst !== 1'b1) begin
                bcnt = 0;
            end else if (busy_w[k] === 1'b1) begin
                bcnt++;
            end else if (bcnt > 0) begin
                check("busy_len", bcnt, NB * P);
                check("ready_after_stop", 32'(in_ready_w[k]), 32'd1);
                check("stop_tick_prev", 32'(prev_tick), 32'd1);
                bcnt = 0;
            end
            prev_tick = tick_w[k];
        end
    end

    // Called at a negedge. Offers d until accepted; returns the number of cycles waited.
    task automatic send(input int k, input logic [8:0] d, input bit push, input bit frc,
                        input bit keep, input logic [8:0] nxt, output int waited);
        exp_t ex;
        waited = 0;
        in_data_w[k]  = d;
        in_valid_w[k] = 1'b1;
        #1;
        while (in_ready_w[k] !== 1'b1 && waited < 2000) begin
            @(negedge clk);
            waited++;
            #1;
        end
        check("accept_in_time", 32'(in_ready_w[k]), 32'd1);
        check("tick_clr_on_accept", 32'(tick_clr_w[k]), 32'd1);
        if (frc) force_tick[k] = 1'b1;
        if (push) begin
            ex.k    = k;
            ex.bits = frame_bits(k, d);
            sb.push_back(ex);
        end
        @(negedge clk);
        force_tick[k] = 1'b0;
        in_valid_w[k] = keep;
        in_data_w[k]  = nxt;
        check("busy_rise", 32'(busy_w[k]), 32'd1);
        check("start_fall", 32'(tx_w[k]), 32'd0);
    endtask

    task automatic wait_frames(input int k, input int target);
        int n;
        n = 0;
        while (frames_seen[k] < target && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("frame_arrived", frames_seen[k], target);
        repeat (2) @(negedge clk);
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin : main
        int w;
        n_rst      = 1'b0;
        in_valid_w = '0;
        force_tick = '0;
        for (int k = 0; k < 4; k++) in_data_w[k] = '0;

        repeat (3) @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            check("rst_tx", 32'(tx_w[k]), 32'd1);
            check("rst_busy", 32'(busy_w[k]), 32'd0);
            check("rst_ready", 32'(in_ready_w[k]), 32'd1);
        end
        #1 n_rst = 1'b1;
        @(negedge clk);
        check("idle_tick_clr", 32'(tick_clr_w[0]), 32'd0);

        // Ticks while idle with nothing offered change nothing.
        force_tick[0] = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("idle_tick_tx", 32'(tx_w[0]), 32'd1);
            check("idle_tick_busy", 32'(busy_w[0]), 32'd0);
        end
        force_tick[0] = 1'b0;

        // 8N1 0xA5 with a tick coincident with acceptance.
        send(0, 9'h0A5, 1'b1, 1'b1, 1'b0, 9'h000, w);
        wait_frames(0, 1);
        check("a5_line", 32'(last_bits[0][9:0]), 32'h34A);

        // in_valid held across two frames; in_data changes mid-frame must not leak.
        send(0, 9'h011, 1'b1, 1'b0, 1'b1, 9'h022, w);
        send(0, 9'h022, 1'b1, 1'b0, 1'b0, 9'h0FF, w);
        check("b2b_accept_cycle", w, 160);
        wait_frames(0, 3);
        repeat (200) @(negedge clk);
        check("b2b_frame_count", frames_seen[0], 3);

        // Reset in the middle of data bit 3, then a clean frame.
        send(0, 9'h05A, 1'b0, 1'b0, 1'b0, 9'h000, w);
        repeat (72) @(negedge clk);
        check("mid_frame_busy", 32'(busy_w[0]), 32'd1);
        #2 n_rst = 1'b0;
        #1;
        check("async_rst_tx", 32'(tx_w[0]), 32'd1);
        check("async_rst_busy", 32'(busy_w[0]), 32'd0);
        check("async_rst_ready", 32'(in_ready_w[0]), 32'd1);
        @(negedge clk);
        @(negedge clk);
        #1 n_rst = 1'b1;
        @(negedge clk);
        send(0, 9'h03C, 1'b1, 1'b0, 1'b0, 9'h000, w);
        wait_frames(0, 4);
        check("3c_line", 32'(last_bits[0][9:0]), 32'h278);

        // Parity configurations.
        send(1, 9'h007, 1'b1, 1'b0, 1'b0, 9'h000, w);
        wait_frames(1, 1);
        check("even_par_07", 32'(last_bits[1][9]), 32'd1);
        send(2, 9'h000, 1'b1, 1'b0, 1'b0, 9'h000, w);
        wait_frames(2, 1);
        check("odd_par_00", 32'(last_bits[2][9]), 32'd1);

        // 7 data bits, two stop bits.
        send(3, 9'h07F, 1'b1, 1'b0, 1'b0, 9'h000, w);
        wait_frames(3, 1);
        check("7n2_stops", 32'(last_bits[3][9:8]), 32'h3);

        repeat (5) @(negedge clk);
        check("sb_drained", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
# uart_tx

Serial transmitter that drives one asynchronous UART frame per accepted byte: start bit, LSB-first data, optional parity, and one or two stop bits. It sits downstream of the baud-rate counter. The counter's single-cycle rollover strobe paces every bit on `tick`. This block pulses `tick_clr` on frame acceptance so the counter restarts phase-aligned to the start bit. Upstream logic presents bytes over a valid/ready handshake.

## Interface
- `DATA_BITS`, default 8: data bits per frame; legal range 5–9.
- `PARITY`, default 0: 0 = none, 1 = odd, 2 = even.
- `STOP_BITS`, default 1: legal values 1 or 2.

- `clk` in 1: clock.
- `n_rst` in 1: reset, asynchronous, active-low.
- `tick` in 1: bit-period strobe from the baud counter; one cycle high per bit period.
- `tick_clr` out 1: combinational; high in the acceptance cycle; wired to the baud counter `clear`.
- `in_data` in DATA_BITS: byte to send.
- `in_valid` in 1: `in_data` is valid.
- `in_ready` out 1: combinational; high exactly when state is IDLE.
- `tx` out 1: serial line, registered, idle high.
- `busy` out 1: registered; high from the cycle after acceptance until return to IDLE.

## Operation
- States: IDLE, START, DATA, PAR, STOP.
- **IDLE**
  - `tx`=1; `tick` is ignored.
  - When `in_valid`&`in_ready`, the byte is accepted:
    - `in_data` is latched into the shift register.
    - Parity is computed from the latched data.
    - The bit counter is cleared.
    - `tick_clr`=1.
    - Next state is START.
- **START**
  - `tx`=0.
  - On `tick`, go to DATA.
- **DATA**
  - `tx` = shift register bit 0.
  - On `tick`:
    - The shift register shifts right.
    - The bit counter increments.
    - After the tick that ends bit DATA_BITS-1, go to PAR if `PARITY`≠0, otherwise to STOP.
- **PAR**
  - Odd parity: `tx` = ~^data.
  - Even parity: `tx` = ^data.
  - On `tick`, go to STOP.
- **STOP**
  - `tx`=1.
  - Stop ticks are counted. On the `STOP_BITS`-th tick, go to IDLE.
- Bit counter width is $clog2(DATA_BITS+1). It counts 0..DATA_BITS-1 and never wraps mid-frame.
- `in_data` changes after acceptance have no effect on the frame in flight.
- `in_valid` while not IDLE is not accepted. The data is held upstream, with no loss and no duplication.
- A `tick` in the acceptance cycle is ignored, and START is still entered. The counter restart via `tick_clr` makes the first START tick arrive one full bit period later.
- **Reset** (asynchronous, any time, including mid-frame):
  - State → IDLE; `tx`=1; `busy`=0; `in_ready`=1; shift register and counters → 0.
  - The in-flight frame is discarded, and the line returns high immediately.
- Illegal parameter values are rejected at elaboration with an assertion.

## Timing
- Acceptance happens in cycle N. `tx` falls at N+1, and `busy` rises at N+1.
- Each bit holds from state entry until the cycle after its terminating `tick`. `tx` updates one cycle after each `tick`.
- With tick period P cycles and the counter cleared at N, every bit on the line lasts exactly P cycles.
- Frame length is (1 + DATA_BITS + (PARITY≠0) + STOP_BITS)·P cycles, measured from N+1.
- The final stop tick is at cycle T. State is IDLE and `in_ready`=1 at T+1, so the earliest next acceptance is T+1.
- Back-to-back frames therefore extend the last stop bit by at least 1 cycle. This is legal UART idle.
- `tick_clr` and `in_ready` are combinational from state and `in_valid`. There is no combinational path from `tick` to any output.

## Test plan
- 8N1, P=16, send 0xA5:
  - `tx` sequence is 0, 1,0,1,0,0,1,0,1, 1, each bit 16 cycles.
  - `in_ready` returns 1 at T+1.
- `PARITY`=2, send 0x07 → parity bit 1. `PARITY`=1, send 0x00 → parity bit 1. Check frame length against the formula.
- `STOP_BITS`=2, `DATA_BITS`=7, send 0x7F → line stays high for 32 cycles after the last data bit before `busy` falls.
- `in_valid` held high continuously with data 0x11 then 0x22:
  - Exactly two frames are sent.
  - 0x22 is accepted the cycle `in_ready` rises.
  - `in_data` changes during frame 1 do not alter its bits.
- `n_rst` pulsed during DATA bit 3 → `tx`=1 and `busy`=0 asynchronously. After release, a fresh 0x3C is sent correctly.
- Tick coincident with acceptance, and ticks while IDLE → no state change other than the accept. The start bit still lasts a full P cycles.
